// File: rtl/feature_flatten_buf_pkg.sv
// Shared definitions for the feature flatten buffer.
// Holds the FILL/DRAIN state encoding, the channel count and the default
// pooled value width used by the top and the per-channel banks.
package feature_flatten_buf_pkg;

  // Number of pooled channels carried per input pixel.
  localparam int N_CH = 3;

  // Width of the channel index register (covers 0..N_CH-1).
  localparam int CH_W = 2;

  // Default width of one pooled, ReLU'd signed value.
  localparam int CONV_BIT_DEF = 12;

  // FILL: accepting pooled pixels. DRAIN: streaming flattened words.
  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/feature_flatten_buf_feat_bank.sv
// feat_bank: one channel's worth of pooled-pixel storage.
// Single synchronous write port, asynchronous (combinational) read port.
// Ports: clk, i_we/i_waddr/i_wdata write side, i_raddr -> o_rdata read side.
// Contents are not reset; the owner tracks which entries hold valid data.
module feat_bank
  import feature_flatten_buf_pkg::*;
#(
  parameter int DEPTH = 36,
  parameter int WIDTH = CONV_BIT_DEF,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/feature_flatten_buf.sv
// feature_flatten_buf: collects a pooled OUT_WIDTH x OUT_HEIGHT x 3 feature
// map pixel by pixel and streams it out channel-major (idx = c*P + pix) to the
// FC stage over a valid/ready interface.
// Ports:
//   clk, rst_n (async active-low)
//   valid_in, max_value_1..3 : one pooled pixel per cycle, no backpressure
//   feat_valid/feat_ready     : output handshake
//   feat_data/feat_idx/feat_last : word, flat index, final-word marker
//   overflow                  : sticky, a pixel had to be dropped
// Optional macro FEAT_BUF_PINGPONG_EN: two bank sets so a new frame can be
// written while the previous one drains. Without it a single set is used and
// pixels arriving during DRAIN are dropped.
module feature_flatten_buf
  import feature_flatten_buf_pkg::*;
#(
  parameter int CONV_BIT   = CONV_BIT_DEF,
  parameter int OUT_WIDTH  = 6,
  parameter int OUT_HEIGHT = 6
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            valid_in,
  input  logic signed [CONV_BIT-1:0]                      max_value_1,
  input  logic signed [CONV_BIT-1:0]                      max_value_2,
  input  logic signed [CONV_BIT-1:0]                      max_value_3,
  output logic                                            feat_valid,
  input  logic                                            feat_ready,
  output logic signed [CONV_BIT-1:0]                      feat_data,
  output logic [$clog2(N_CH*OUT_WIDTH*OUT_HEIGHT)-1:0]    feat_idx,
  output logic                                            feat_last,
  output logic                                            overflow
);

  localparam int P     = OUT_WIDTH * OUT_HEIGHT;
  localparam int PIX_W = (P > 1) ? $clog2(P) : 1;
  localparam int IDX_W = $clog2(N_CH * P);

`ifdef FEAT_BUF_PINGPONG_EN
  localparam int N_SET = 2;
`else
  localparam int N_SET = 1;
`endif

  localparam logic [PIX_W-1:0] PIX_LAST    = PIX_W'(P - 1);
  // feat_last is registered, so it is raised on the handshake of idx 3P-2.
  localparam logic [IDX_W-1:0] IDX_LAST_M1 = IDX_W'(N_CH * P - 2);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t            r_state;
  logic [PIX_W-1:0]  r_wr_pix;
  logic [PIX_W-1:0]  r_rd_pix;
  logic [CH_W-1:0]   r_rd_ch;
  logic [IDX_W-1:0]  r_rd_idx;
  logic              r_feat_valid;
  logic              r_feat_last;
  logic              r_overflow;

  logic              w_wr_en;
  logic              w_wr_done;
  logic              w_hs;
  logic              w_hs_last;
  logic              w_drain_go;
  logic              w_wr_sel;

  assign w_wr_done = w_wr_en && (r_wr_pix == PIX_LAST);
  assign w_hs      = r_feat_valid && feat_ready;
  assign w_hs_last = w_hs && r_feat_last;

`ifdef FEAT_BUF_PINGPONG_EN
  // r_full[s]: set s holds a complete frame that has not finished draining.
  // Sets complete and drain in the same alternating order, so r_rd_set is
  // always the oldest complete set.
  logic [1:0] r_full;
  logic       r_wr_set;
  logic       r_rd_set;
  logic       w_next_ready;

  assign w_wr_sel = r_wr_set;
  // A write only lands in a set that is not holding an undrained frame;
  // when the write set is full, both sets are full.
  assign w_wr_en  = valid_in && !r_full[r_wr_set];
  // Start draining the cycle after a set completes (or immediately if one
  // is already waiting).
  assign w_drain_go   = r_full[r_rd_set] || (w_wr_done && (r_wr_set == r_rd_set));
  // On the final handshake, keep streaming if the other set is ready.
  assign w_next_ready = r_full[~r_rd_set] || (w_wr_done && (r_wr_set != r_rd_set));
`else
  assign w_wr_sel   = 1'b0;
  assign w_wr_en    = valid_in && (r_state == ST_FILL);
  assign w_drain_go = w_wr_done;
`endif

  // ---------------------------------------------------------------------
  // Write side: pixel counter, set bookkeeping, sticky overflow
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_pix   <= '0;
      r_overflow <= 1'b0;
`ifdef FEAT_BUF_PINGPONG_EN
      r_full     <= '0;
      r_wr_set   <= 1'b0;
`endif
    end else begin
      if (w_wr_en) begin
        if (w_wr_done) begin
          r_wr_pix <= '0;
`ifdef FEAT_BUF_PINGPONG_EN
          r_full[r_wr_set] <= 1'b1;
          r_wr_set         <= ~r_wr_set;
`endif
        end else begin
          r_wr_pix <= r_wr_pix + 1'b1;
        end
      end
`ifdef FEAT_BUF_PINGPONG_EN
      // The set being drained is never the set being completed, so these
      // two r_full updates never target the same bit.
      if (w_hs_last) begin
        r_full[r_rd_set] <= 1'b0;
      end
`endif
      if (valid_in && !w_wr_en) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read side FSM with registered handshake outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_FILL;
      r_feat_valid <= 1'b0;
      r_feat_last  <= 1'b0;
      r_rd_pix     <= '0;
      r_rd_ch      <= '0;
      r_rd_idx     <= '0;
`ifdef FEAT_BUF_PINGPONG_EN
      r_rd_set     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_drain_go) begin
            r_state      <= ST_DRAIN;
            r_feat_valid <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_hs_last) begin
            r_rd_pix    <= '0;
            r_rd_ch     <= '0;
            r_rd_idx    <= '0;
            r_feat_last <= 1'b0;
`ifdef FEAT_BUF_PINGPONG_EN
            r_rd_set <= ~r_rd_set;
            if (!w_next_ready) begin
              r_state      <= ST_FILL;
              r_feat_valid <= 1'b0;
            end
`else
            r_state      <= ST_FILL;
            r_feat_valid <= 1'b0;
`endif
          end else if (w_hs) begin
            r_rd_idx    <= r_rd_idx + 1'b1;
            r_feat_last <= (r_rd_idx == IDX_LAST_M1);
            // Pixel wrap moves on to the next channel bank.
            if (r_rd_pix == PIX_LAST) begin
              r_rd_pix <= '0;
              r_rd_ch  <= r_rd_ch + 1'b1;
            end else begin
              r_rd_pix <= r_rd_pix + 1'b1;
            end
          end
        end
        default: begin
          r_state      <= ST_FILL;
          r_feat_valid <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Bank array: N_SET x N_CH single-write, async-read banks
  // ---------------------------------------------------------------------
  logic [CONV_BIT-1:0] w_wr_dat [N_CH];
  logic [CONV_BIT-1:0] w_rd_dat [N_SET][N_CH];
  logic [CONV_BIT-1:0] w_set_dat [N_CH];

  assign w_wr_dat[0] = max_value_1;
  assign w_wr_dat[1] = max_value_2;
  assign w_wr_dat[2] = max_value_3;

  for (genvar s = 0; s < N_SET; s++) begin : g_set
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      feat_bank #(
        .DEPTH (P),
        .WIDTH (CONV_BIT),
        .AW    (PIX_W)
      ) u_bank (
        .clk     (clk),
        .i_we    (w_wr_en && (w_wr_sel == 1'(s))),
        .i_waddr (r_wr_pix),
        .i_wdata (w_wr_dat[c]),
        .i_raddr (r_rd_pix),
        .o_rdata (w_rd_dat[s][c])
      );
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_sel
`ifdef FEAT_BUF_PINGPONG_EN
    assign w_set_dat[c] = r_rd_set ? w_rd_dat[1][c] : w_rd_dat[0][c];
`else
    assign w_set_dat[c] = w_rd_dat[0][c];
`endif
  end

  // Combinational read of the current bank; masked to zero outside DRAIN so
  // the bus is quiet (and defined) while filling.
  logic [CONV_BIT-1:0] w_feat_data;

  always_comb begin
    w_feat_data = '0;
    if (r_feat_valid) begin
      case (r_rd_ch)
        2'd0:    w_feat_data = w_set_dat[0];
        2'd1:    w_feat_data = w_set_dat[1];
        2'd2:    w_feat_data = w_set_dat[2];
        default: w_feat_data = '0;
      endcase
    end
  end

  assign feat_valid = r_feat_valid;
  assign feat_data  = w_feat_data;
  assign feat_idx   = r_rd_idx;
  assign feat_last  = r_feat_last;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_feature_flatten_buf.sv
module tb_feature_flatten_buf;

  localparam int CB = 12;
  localparam int P  = 36;
  localparam int NW = 108;
  localparam int IW = 7;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 valid_in;
  logic signed [CB-1:0] max_value_1, max_value_2, max_value_3;
  logic                 feat_valid;
  logic                 feat_ready = 1'b0;
  logic signed [CB-1:0] feat_data;
  logic [IW-1:0]        feat_idx;
  logic                 feat_last;
  logic                 overflow;

  feature_flatten_buf #(
    .CONV_BIT   (CB),
    .OUT_WIDTH  (6),
    .OUT_HEIGHT (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .max_value_1 (max_value_1),
    .max_value_2 (max_value_2),
    .max_value_3 (max_value_3),
    .feat_valid  (feat_valid),
    .feat_ready  (feat_ready),
    .feat_data   (feat_data),
    .feat_idx    (feat_idx),
    .feat_last   (feat_last),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_hs  = 0;

  typedef struct packed {
    logic [CB-1:0] dat;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  exp_t sb[$];

  logic signed [CB-1:0] pat [3][P];
  logic toggle_rdy = 1'b0;
  logic rdy_level  = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Ready generator: steady level, or alternating 1-0-1-0 every cycle.
  always @(posedge clk) begin
    #1;
    feat_ready = toggle_rdy ? ~feat_ready : rdy_level;
  end

  // Monitor / scoreboard: pops on every handshake, and checks that a
  // stalled word is held unchanged into the next cycle.
  logic held_vld = 1'b0;
  exp_t held;
  exp_t got;
  exp_t e_pop;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_vld = 1'b0;
    end else begin
      got = {feat_data, feat_idx, feat_last};
      if (held_vld) chk("stall_hold", {feat_valid, got}, {1'b1, held});
      if (feat_valid && feat_ready) begin
        n_hs++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got idx %0d data %0d, expected no word", feat_idx, feat_data);
        end else begin
          e_pop = sb.pop_front();
          chk("word", got, e_pop);
        end
        held_vld = 1'b0;
      end else if (feat_valid) begin
        held_vld = 1'b1;
        held     = got;
      end else begin
        held_vld = 1'b0;
      end
    end
  end

  task automatic fill_pat(input int kind);
    for (int p = 0; p < P; p++) begin
      case (kind)
        0: begin pat[0][p] = CB'(p);       pat[1][p] = CB'(100 + p); pat[2][p] = CB'(-(p + 1)); end
        1: begin pat[0][p] = CB'(3 * p);   pat[1][p] = CB'(7 * p);   pat[2][p] = CB'(200 - p);  end
        2: begin pat[0][p] = CB'(500 + p); pat[1][p] = CB'(-p);      pat[2][p] = CB'(1000);     end
        3: begin pat[0][p] = 12'sd2047;    pat[1][p] = 12'sd0;       pat[2][p] = -12'sd2048;    end
        default: begin pat[0][p] = CB'(1500 + p); pat[1][p] = CB'(-700); pat[2][p] = CB'(33); end
      endcase
    end
  endtask

  task automatic push_exp();
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < P; p++) begin
        exp_t e;
        e.dat  = pat[c][p];
        e.idx  = IW'(c * P + p);
        e.last = ((c * P + p) == NW - 1);
        sb.push_back(e);
      end
    end
  endtask

  // Drives n pixels from pat back-to-back; valid_in is left high.
  task automatic drive_pix(input int n);
    for (int p = 0; p < n; p++) begin
      @(posedge clk);
      #1;
      valid_in    = 1'b1;
      max_value_1 = pat[0][p];
      max_value_2 = pat[1][p];
      max_value_3 = pat[2][p];
    end
  endtask

  task automatic end_pix();
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while (sb.size() != 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: %0d words left, expected 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
    chk({name, "_back_to_fill"}, feat_valid, 0);
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_valid"}, feat_valid, 0);
    chk({name, "_last"},  feat_last, 0);
    chk({name, "_idx"},   feat_idx, 0);
    chk({name, "_data"},  feat_data, 0);
    chk({name, "_ovf"},   overflow, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    valid_in    = 1'b0;
    max_value_1 = '0;
    max_value_2 = '0;
    max_value_3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic frame, ready held high; first valid one cycle after last write.
    fill_pat(0);
    push_exp();
    drive_pix(P);
    @(negedge clk);
    chk("valid_before_last_write", feat_valid, 0);
    end_pix();
    @(negedge clk);
    chk("first_valid", feat_valid, 1);
    chk("first_idx", feat_idx, 0);
    wait_drain("frame0");

    // Same frame with ready toggling every cycle.
    n_hs = 0;
    toggle_rdy = 1'b1;
    fill_pat(0);
    push_exp();
    drive_pix(P);
    end_pix();
    wait_drain("stall_frame");
    chk("stall_handshakes", n_hs, NW);
    toggle_rdy = 1'b0;
    rdy_level  = 1'b1;
    repeat (2) @(posedge clk);

`ifdef FEAT_BUF_PINGPONG_EN
    // Back-to-back frames: F1 written while F0 drains.
    fill_pat(0);
    push_exp();
    drive_pix(P);
    fill_pat(1);
    push_exp();
    drive_pix(P);
    end_pix();
    wait_drain("pingpong");
    chk("pingpong_no_ovf", overflow, 0);
`else
    // Five pixels arriving during a stalled drain are dropped.
    rdy_level = 1'b0;
    fill_pat(1);
    push_exp();
    drive_pix(P);
    end_pix();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      valid_in    = 1'b1;
      max_value_1 = 12'sd777;
      max_value_2 = -12'sd777;
      max_value_3 = 12'sd55;
      @(posedge clk);
      #1 valid_in = 1'b0;
    end
    @(negedge clk);
    chk("ovf_set", overflow, 1);
    rdy_level = 1'b1;
    wait_drain("ovf_frame");
    chk("ovf_sticky", overflow, 1);
    fill_pat(2);
    push_exp();
    drive_pix(P);
    end_pix();
    wait_drain("after_ovf");
    chk("ovf_still_sticky", overflow, 1);
`endif

    // Reset in the middle of a frame discards it.
    fill_pat(4);
    drive_pix(20);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    chk_reset_outs("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    fill_pat(2);
    push_exp();
    drive_pix(P);
    end_pix();
    wait_drain("fresh");

    // Extreme values pass bit-exact.
    fill_pat(3);
    push_exp();
    drive_pix(P);
    end_pix();
    wait_drain("maxmin");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/feature_flatten_buf.md
FEATURE_FLATTEN_BUF -- requirements
Module: feature_flatten_buf

Interface
REQ-001 SHALL have parameter CONV_BIT, default 12, width of each pooled signed value.
REQ-002 SHALL have parameter OUT_WIDTH, default 6, pooled map width in pixels.
REQ-003 SHALL have parameter OUT_HEIGHT, default 6, pooled map height in pixels.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port valid_in  input  1  one pooled pixel (3 channels) present this cycle; no backpressure.
REQ-007 SHALL have ports max_value_1, max_value_2, max_value_3  input  CONV_BIT signed  pooled, ReLU'd channel values.
REQ-008 SHALL have port feat_valid  output  1  flattened feature word available.
REQ-009 SHALL have port feat_ready  input  1  consumer (FC stage) accepts the word.
REQ-010 SHALL have port feat_data  output  CONV_BIT signed  flattened feature value.
REQ-011 SHALL have port feat_idx  output  clog2(3*P) bits  flat index of feat_data, where P = OUT_WIDTH*OUT_HEIGHT.
REQ-012 SHALL have port feat_last  output  1  asserted with the final word (idx 3P-1).
REQ-013 SHALL have port overflow  output  1  sticky: an input pixel was dropped.

Function
REQ-014 SHALL hold three banks (one per channel) of P entries each, addressed by the pixel write counter wr_pix.
REQ-015 SHALL use a two-state FSM: FILL (accept input) and DRAIN (stream output).
REQ-016 In FILL, valid_in SHALL write max_value_k into bank k at wr_pix and increment wr_pix.
REQ-017 A write with wr_pix = P-1 SHALL clear wr_pix and move the FSM to DRAIN on the next edge.
REQ-018 In DRAIN, feat_valid SHALL be 1; it SHALL be 0 in FILL. The first feat_valid is in the cycle after the final write.
REQ-019 Output order SHALL be channel-major (C,H,W flatten): idx = c*P + pix; bank 1 pixels 0..P-1, then bank 2, then bank 3.
REQ-020 feat_data SHALL be a combinational read of the current bank/address; feat_data, feat_idx and feat_last SHALL be stable while feat_valid=1 and feat_ready=0.
REQ-021 A handshake (feat_valid & feat_ready) SHALL advance the read pointer by one; pixel wrap SHALL advance the channel.
REQ-022 A handshake with feat_last=1 SHALL reset the read pointers and return the FSM to FILL on the next edge.
REQ-023 Without pingpong, valid_in in DRAIN SHALL be dropped and SHALL set overflow; overflow clears only on reset.
REQ-024 Values SHALL be stored and output bit-exact; there is no arithmetic or saturation.

Reset
REQ-025 On rst_n low: FSM=FILL; wr_pix, read pointers, bank select = 0; feat_valid=0, feat_last=0, feat_idx=0, feat_data=0 (FILL read is masked to 0), overflow=0.
REQ-026 Bank contents SHALL NOT need reset; a reset mid-frame discards the partial frame, and the next valid_in is written to pixel 0.

Configuration
REQ-027 Macro FEAT_BUF_PINGPONG_EN SHALL, when defined, duplicate the banks (A/B): writes fill one set while the other drains.
REQ-028 With FEAT_BUF_PINGPONG_EN, FILL and DRAIN SHALL run concurrently; a completed write set is queued for drain.
REQ-029 With FEAT_BUF_PINGPONG_EN, a drain SHALL start the cycle after a set completes, or the cycle after the last handshake if the other set is already full.
REQ-030 With FEAT_BUF_PINGPONG_EN, overflow SHALL be set only if valid_in arrives while both sets are full and not yet drained.
REQ-031 Without the macro, behaviour SHALL be exactly REQ-014..REQ-024 with a single bank set.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (FILL, DRAIN), N_CH=3, and the CONV_BIT default.
REQ-033 One sub-module, feat_bank (single-write-port, async-read P x CONV_BIT array), SHALL be instantiated per channel (and per set with pingpong).

Verification
REQ-034 Reset, then 36 valid_in pixels with ch1=pix, ch2=100+pix, ch3=-(pix+1); feat_ready=1 -> 108 words: idx0=0, idx35=35, idx36=100, idx107=-36; feat_last only at idx107; FSM returns to FILL.
REQ-035 Same frame with feat_ready toggled 1-0-1-0 -> each word held stable while stalled; 108 handshakes total; no word is lost or duplicated.
REQ-036 Without pingpong, 5 valid_in pulses during DRAIN -> overflow=1 and stays 1; drained data is unchanged; the next frame starts at pix 0.
REQ-037 With FEAT_BUF_PINGPONG_EN, back-to-back frames F0 and F1 with feat_ready=1 -> F0 is fully drained, then F1; overflow=0.
REQ-038 rst_n pulsed low after 20 pixels, then 36 fresh pixels -> output contains only the fresh frame; the first word equals fresh pixel 0 of ch1.
REQ-039 Max/min data: ch1=2047 and ch2=0 on all pixels -> feat_data=2047 for idx0..35 and 0 for idx36..71, bit-exact.
